// File: rtl/float_normalizer_if.sv
// Handshake bundle between the FP datapath, the normalizer and FloatRounding.
// slave = normalizer view, master = producer/consumer view.
interface float_normalizer_if #(
    parameter int N   = 24,
    parameter int EXP = 8
);
    logic           InValid;
    logic           InReady;
    logic [N+2:0]   rawMant;
    logic [EXP-1:0] rawExp;
    logic           stickyIn;
    logic           OutValid;
    logic           OutReady;
    logic [N-1:0]   normMant;
    logic [EXP-1:0] normExp;
    logic           R;
    logic           S;
    logic           zero;
    logic           overflow;
    logic           underflow;

    modport slave (
        input  InValid, rawMant, rawExp, stickyIn, OutReady,
        output InReady, OutValid, normMant, normExp, R, S,
               zero, overflow, underflow
    );

    modport master (
        output InValid, rawMant, rawExp, stickyIn, OutReady,
        input  InReady, OutValid, normMant, normExp, R, S,
               zero, overflow, underflow
    );
endinterface

// File: rtl/float_normalizer.sv
// Iterative post-arithmetic normalizer: one right shift on carry,
// otherwise one left shift per cycle until the hidden bit is set.
module float_normalizer #(
    parameter int N   = 24,
    parameter int EXP = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    float_normalizer_if.slave   io
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [EXP-1:0] EXP_ONES = '1;
    localparam logic [EXP-1:0] EXP_SAT  = EXP_ONES - 1'b1;
    localparam logic [EXP-1:0] EXP_ONE  = {{(EXP-1){1'b0}}, 1'b1};

    state_t         r_state;
    logic [N+1:0]   r_work;
    logic [EXP-1:0] r_exp;
    logic           r_sticky;
    logic           r_zero;
    logic           r_ovf;
    logic           r_unf;

    state_t         w_state_nxt;
    logic [N+1:0]   w_work_nxt;
    logic [EXP-1:0] w_exp_nxt;
    logic           w_sticky_nxt;
    logic           w_zero_nxt;
    logic           w_ovf_nxt;
    logic           w_unf_nxt;
    logic           w_accept;
    logic [N+1:0]   w_shl;
    logic [EXP-1:0] w_dec;

    assign w_accept = io.InValid && (r_state == S_IDLE);
    assign w_shl    = {r_work[N:0], 1'b0};
    assign w_dec    = r_exp - 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_exp_nxt    = r_exp;
        w_sticky_nxt = r_sticky;
        w_zero_nxt   = r_zero;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_zero_nxt   = 1'b0;
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b0;
                    w_work_nxt   = io.rawMant[N+1:0];
                    w_exp_nxt    = io.rawExp;
                    w_sticky_nxt = io.stickyIn;
                    w_state_nxt  = S_DONE;
                    if (io.rawMant == '0 && !io.stickyIn) begin
                        w_zero_nxt = 1'b1;
                        w_exp_nxt  = '0;
                    end else if (io.rawMant[N+2]) begin
                        // Carry: drop to the hidden position, lost bit joins sticky
                        w_work_nxt   = io.rawMant[N+2:1];
                        w_sticky_nxt = io.stickyIn | io.rawMant[0];
                        if (io.rawExp >= EXP_SAT) begin
                            w_exp_nxt = EXP_ONES;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_exp_nxt = io.rawExp + 1'b1;
                        end
                    end else if (io.rawMant[N+1]) begin
                        w_state_nxt = S_DONE;
                    end else if (io.rawExp <= EXP_ONE) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_shl;
                w_exp_nxt  = w_dec;
                if (w_shl[N+1]) begin
                    w_state_nxt = S_DONE;
                end else if (w_dec == EXP_ONE) begin
                    w_unf_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (io.OutReady) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_exp    <= '0;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (i_flush) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_exp    <= '0;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_work   <= w_work_nxt;
            r_exp    <= w_exp_nxt;
            r_sticky <= w_sticky_nxt;
            r_zero   <= w_zero_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
        end
    end

    assign io.InReady   = (r_state == S_IDLE);
    assign io.OutValid  = (r_state == S_DONE);
    assign io.normMant  = r_work[N+1:2];
    assign io.R         = r_work[1];
    assign io.S         = r_work[0] | r_sticky;
    assign io.normExp   = r_exp;
    assign io.zero      = r_zero;
    assign io.overflow  = r_ovf;
    assign io.underflow = r_unf;
endmodule

// File: tb/tb_float_normalizer.sv
// Directed-vector bench for float_normalizer (N=24, EXP=8).
// Result bundle = {normMant, R, S, normExp, zero, overflow, underflow}.
module tb_float_normalizer;
    localparam int N   = 24;
    localparam int EXP = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    float_normalizer_if #(.N(N), .EXP(EXP)) bus ();

    float_normalizer #(.N(N), .EXP(EXP)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .io      (bus)
    );

    wire [36:0] got = {bus.normMant, bus.R, bus.S, bus.normExp,
                       bus.zero, bus.overflow, bus.underflow};
    wire [1:0]  hs  = {bus.OutValid, bus.InReady};

    task automatic send(input logic [26:0] m, input logic [7:0] e,
                        input logic s);
        @(negedge clk);
        bus.InValid  = 1'b1;
        bus.rawMant  = m;
        bus.rawExp   = e;
        bus.stickyIn = s;
        @(posedge clk);
        #1 bus.InValid = 1'b0;
    endtask

    // Counts edges from the accept edge until OutValid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.OutValid && lat < 60) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic pop;
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1 bus.OutReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (hs !== 2'b01) begin n_fail++;
            $display("FAIL reset_hs got=%b exp=01", hs); end
        n_cmp++; if (got !== 37'd0) begin n_fail++;
            $display("FAIL reset_out got=%h exp=0", got); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (hs !== 2'b01) begin n_fail++;
            $display("FAIL reset_rel_hs got=%b exp=01", hs); end
    endtask

    task automatic test_carry;
        int lat;
        send(27'h6000003, 8'h80, 1'b1); wait_out(lat);
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL carry_lat got=%0d exp=1", lat); end
        n_cmp++; if (got !== {24'hC00000, 1'b0, 1'b1, 8'h81, 3'b000}) begin
            n_fail++; $display("FAIL carry got=%h", got); end
        pop;
        n_cmp++; if (hs !== 2'b01) begin n_fail++;
            $display("FAIL carry_pop got=%b exp=01", hs); end
    endtask

    task automatic test_normal;
        int lat;
        send(27'h2000006, 8'h40, 1'b0); wait_out(lat);
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL normal_lat got=%0d exp=1", lat); end
        n_cmp++; if (got !== {24'h800001, 1'b1, 1'b0, 8'h40, 3'b000}) begin
            n_fail++; $display("FAIL normal got=%h", got); end
        pop;
    endtask

    task automatic test_shift;
        int lat;
        send(27'h0400004, 8'h80, 1'b0); wait_out(lat);
        n_cmp++; if (lat !== 4) begin n_fail++;
            $display("FAIL shift3_lat got=%0d exp=4", lat); end
        n_cmp++; if (got !== {24'h800008, 1'b0, 1'b0, 8'h7D, 3'b000}) begin
            n_fail++; $display("FAIL shift3 got=%h", got); end
        pop;
        send(27'h0000001, 8'h80, 1'b0); wait_out(lat);
        n_cmp++; if (lat !== 26) begin n_fail++;
            $display("FAIL shiftmax_lat got=%0d exp=26", lat); end
        n_cmp++; if (got !== {24'h800000, 1'b0, 1'b0, 8'h67, 3'b000}) begin
            n_fail++; $display("FAIL shiftmax got=%h", got); end
        pop;
    endtask

    task automatic test_underflow;
        int lat;
        send(27'h0100000, 8'h03, 1'b0); wait_out(lat);
        n_cmp++; if (lat !== 3) begin n_fail++;
            $display("FAIL unf_lat got=%0d exp=3", lat); end
        n_cmp++; if (got !== {24'h100000, 1'b0, 1'b0, 8'h01, 3'b001}) begin
            n_fail++; $display("FAIL unf got=%h", got); end
        pop;
        send(27'h0100000, 8'h01, 1'b0); wait_out(lat);
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL unf_imm_lat got=%0d exp=1", lat); end
        n_cmp++; if (got !== {24'h040000, 1'b0, 1'b0, 8'h01, 3'b001}) begin
            n_fail++; $display("FAIL unf_imm got=%h", got); end
        pop;
    endtask

    task automatic test_overflow;
        int lat;
        send(27'h4000000, 8'hFE, 1'b0); wait_out(lat);
        n_cmp++; if (got !== {24'h800000, 1'b0, 1'b0, 8'hFF, 3'b010}) begin
            n_fail++; $display("FAIL ovf got=%h", got); end
        pop;
        send(27'h4000000, 8'hFD, 1'b0); wait_out(lat);
        n_cmp++; if (got !== {24'h800000, 1'b0, 1'b0, 8'hFE, 3'b000}) begin
            n_fail++; $display("FAIL ovf_edge got=%h", got); end
        pop;
    endtask

    task automatic test_zero;
        int lat;
        send(27'h0000000, 8'h55, 1'b0); wait_out(lat);
        n_cmp++; if (lat !== 1) begin n_fail++;
            $display("FAIL zero_lat got=%0d exp=1", lat); end
        n_cmp++; if (got !== {24'h000000, 1'b0, 1'b0, 8'h00, 3'b100}) begin
            n_fail++; $display("FAIL zero got=%h", got); end
        pop;
        send(27'h0000000, 8'h03, 1'b1); wait_out(lat);
        n_cmp++; if (got !== {24'h000000, 1'b0, 1'b1, 8'h01, 3'b001}) begin
            n_fail++; $display("FAIL zero_sticky got=%h", got); end
        pop;
    endtask

    task automatic test_backpressure;
        int lat;
        send(27'h2000006, 8'h40, 1'b0); wait_out(lat);
        bus.InValid = 1'b1;
        bus.rawMant = 27'h6000003;
        bus.rawExp  = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (got !== {24'h800001, 1'b1, 1'b0, 8'h40, 3'b000} ||
                hs !== 2'b10) begin
                n_fail++;
                $display("FAIL bp_hold%0d got=%h hs=%b", i, got, hs);
            end
        end
        bus.InValid = 1'b0;
        pop;
        n_cmp++; if (hs !== 2'b01) begin n_fail++;
            $display("FAIL bp_pop got=%b exp=01", hs); end
    endtask

    task automatic test_back_to_back;
        int lat;
        send(27'h4000000, 8'hFF, 1'b0); wait_out(lat);
        pop;
        send(27'h2000000, 8'h22, 1'b0); wait_out(lat);
        n_cmp++; if (got !== {24'h800000, 1'b0, 1'b0, 8'h22, 3'b000}) begin
            n_fail++; $display("FAIL b2b_flags got=%h", got); end
        pop;
    endtask

    task automatic test_reset_mid_shift;
        send(27'h0000001, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (hs !== 2'b01 || got !== 37'd0) begin n_fail++;
            $display("FAIL rst_mid got=%h hs=%b", got, hs); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (hs !== 2'b01) begin n_fail++;
            $display("FAIL rst_mid_rel got=%b exp=01", hs); end
    endtask

    task automatic test_flush;
        send(27'h0000001, 8'h80, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_cmp++; if (hs !== 2'b01 || got !== 37'd0) begin n_fail++;
            $display("FAIL flush got=%h hs=%b", got, hs); end
    endtask

    initial begin
        bus.InValid  = 1'b0;
        bus.rawMant  = '0;
        bus.rawExp   = '0;
        bus.stickyIn = 1'b0;
        bus.OutReady = 1'b0;
        test_reset();
        test_carry();
        test_normal();
        test_shift();
        test_underflow();
        test_overflow();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_flush();
        test_normal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
